// File: rtl/sram_bus_arbiter_if.sv
// Bus-side bundle of the SRAM arbiter: per-port request fields driven by
// the masters and the shared completion/response signals driven back.
interface sram_bus_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int DW     = 32
);
  localparam int NL = DW / 8;

  logic [NPORTS-1:0]    i_cyc;
  logic [NPORTS*32-1:0] i_adr;
  logic [NPORTS-1:0]    i_we;
  logic [NPORTS*DW-1:0] i_dat;
  logic [NPORTS*NL-1:0] i_sel;
  logic [NPORTS-1:0]    o_ack;
  logic [DW-1:0]        o_rdt;
  logic                 o_err;
  logic [2:0]           o_grant;

  modport master (
    output i_cyc, i_adr, i_we, i_dat, i_sel,
    input  o_ack, o_rdt, o_err, o_grant
  );

  modport slave (
    input  i_cyc, i_adr, i_we, i_dat, i_sel,
    output o_ack, o_rdt, o_err, o_grant
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM macro among
// NPORTS bus masters. Each transaction takes IDLE -> ACCESS -> ACK, so a
// single port sees its ack two cycles after its request is sampled.
module sram_bus_arbiter #(
  parameter int NPORTS = 3,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_bus_arbiter_if.slave   bus,
  output logic                ram_en,
  output logic [AW-1:0]       ram_a,
  output logic [DW/8-1:0]     ram_we,
  output logic [DW-1:0]       ram_di,
  input  logic [DW-1:0]       ram_do
);

  localparam int NL = DW / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] rrPtr_q, rrPtr_d;
  logic       justAcked_q, justAcked_d;
  logic       oor_q, oor_d;
  logic       readAck_q, readAck_d;

  logic [31:0]       selAdr;
  logic              selWe;
  logic [DW-1:0]     selDat;
  logic [NL-1:0]     selSel;
  logic              outOfRange;
  logic [AW-1:0]     wordAdr;

  logic [NPORTS-1:0] eligible;
  logic              winFound;
  logic [2:0]        winIdx;
  logic              ramLive;

  // Route the granted port's request fields onto one set of wires.
  always_comb begin
    selAdr = '0;
    selWe  = 1'b0;
    selDat = '0;
    selSel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (grant_q == 3'(p)) begin
        selAdr = bus.i_adr[32*p +: 32];
        selWe  = bus.i_we[p];
        selDat = bus.i_dat[DW*p +: DW];
        selSel = bus.i_sel[NL*p +: NL];
      end
    end
    outOfRange = |selAdr[31:AW+2];
    wordAdr    = selAdr[AW+1:2];
  end

  // Round-robin search from rrPtr_q; the port just acked sits out one idle
  // cycle so a still-held cyc is not served twice. With a single master
  // there is nobody to yield to, so it is never masked and keeps the
  // one-transaction-per-three-cycles rate.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NPORTS; p++) begin
      eligible[p] = bus.i_cyc[p] &&
                    !((NPORTS > 1) && justAcked_q && (grant_q == 3'(p)));
    end
    winFound = 1'b0;
    winIdx   = 3'd0;
    for (int k = 0; k < NPORTS; k++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (!winFound && eligible[p] && (p == ((int'(rrPtr_q) + k) % NPORTS))) begin
          winFound = 1'b1;
          winIdx   = 3'(p);
        end
      end
    end
  end

  // Transaction sequencing and pointer/mask bookkeeping.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rrPtr_d     = rrPtr_q;
    justAcked_d = justAcked_q;
    oor_d       = oor_q;
    readAck_d   = readAck_q;
    case (state_q)
      IDLE: begin
        justAcked_d = 1'b0;
        if (winFound) begin
          state_d = ACCESS;
          grant_d = winIdx;
          rrPtr_d = ((int'(winIdx) + 1) >= NPORTS) ? 3'd0 : (winIdx + 3'd1);
        end
      end
      ACCESS: begin
        state_d   = ACK;
        oor_d     = outOfRange;
        readAck_d = !outOfRange && !selWe;
      end
      ACK: begin
        state_d     = IDLE;
        justAcked_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 3'd0;
      rrPtr_q     <= 3'd0;
      justAcked_q <= 1'b0;
      oor_q       <= 1'b0;
      readAck_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rrPtr_q     <= rrPtr_d;
      justAcked_q <= justAcked_d;
      oor_q       <= oor_d;
      readAck_q   <= readAck_d;
    end
  end

  // RAM macro drive; reset kills enable/write-enable immediately so an
  // interrupted write never commits.
  always_comb begin
    ramLive = rst_n && (state_q == ACCESS) && !outOfRange;
    ram_en  = ramLive;
    ram_we  = (ramLive && selWe) ? selSel : '0;
    ram_a   = (state_q == ACCESS) ? wordAdr : '0;
    ram_di  = (state_q == ACCESS) ? selDat : '0;
  end

  // Completion signalling back to the masters.
  always_comb begin
    bus.o_ack = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if ((state_q == ACK) && (grant_q == 3'(p))) begin
        bus.o_ack[p] = 1'b1;
      end
    end
    bus.o_err   = (state_q == ACK) && oor_q;
    bus.o_rdt   = ((state_q == ACK) && readAck_q) ? ram_do : '0;
    bus.o_grant = (state_q != IDLE) ? grant_q : 3'd0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized masters,
// all checked against a transaction-level reference model.
module tb_sram_bus_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main DUT and its behavioural RAM macro
  sram_bus_arbiter_if #(.NPORTS(NP), .DW(DW)) bus ();
  logic          ramEn;
  logic [AW-1:0] ramA;
  logic [NL-1:0] ramWe;
  logic [DW-1:0] ramDi;
  logic [DW-1:0] ramDo;

  sram_bus_arbiter #(.NPORTS(NP), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_en(ramEn), .ram_a(ramA), .ram_we(ramWe), .ram_di(ramDi), .ram_do(ramDo)
  );

  logic [DW-1:0] physMem [32];
  logic [DW-1:0] initMem [32];
  logic          loadMem = 1'b0;

  // Synchronous read-first RAM with byte enables
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 32; i++) physMem[i] <= initMem[i];
    end else if (ramEn) begin
      ramDo <= physMem[ramA];
      for (int b = 0; b < NL; b++)
        if (ramWe[b]) physMem[ramA][8*b +: 8] <= ramDi[8*b +: 8];
    end
  end

  // Master-side request registers, driven onto the interface
  logic        mCyc [NP];
  logic        mWe  [NP];
  logic [31:0] mAdr [NP];
  logic [31:0] mDat [NP];
  logic [3:0]  mSel [NP];
  logic        waitAck [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bus.i_cyc[p]          = mCyc[p];
      bus.i_we[p]           = mWe[p];
      bus.i_adr[32*p +: 32] = mAdr[p];
      bus.i_dat[32*p +: 32] = mDat[p];
      bus.i_sel[4*p +: 4]   = mSel[p];
    end
  end

  // Single-port DUT (NPORTS=1, DW=16, AW=4) and its RAM
  sram_bus_arbiter_if #(.NPORTS(1), .DW(16)) bus1 ();
  logic        ram1En;
  logic [3:0]  ram1A;
  logic [1:0]  ram1We;
  logic [15:0] ram1Di;
  logic [15:0] ram1Do;
  logic [15:0] phys1Mem [16];

  sram_bus_arbiter #(.NPORTS(1), .DW(16), .AW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .ram_en(ram1En), .ram_a(ram1A), .ram_we(ram1We), .ram_di(ram1Di), .ram_do(ram1Do)
  );

  always @(posedge clk) begin
    if (ram1En) begin
      ram1Do <= phys1Mem[ram1A];
      for (int b = 0; b < 2; b++)
        if (ram1We[b]) phys1Mem[ram1A][8*b +: 8] <= ram1Di[8*b +: 8];
    end
  end

  // Reference model: phase 0 idle, 1 RAM access, 2 acknowledge
  int          mPhase, mPtr, mGrant;
  bit          mJust;
  logic [31:0] refMem [32];
  logic [31:0] tAdr, tDat;
  logic [3:0]  tSel;
  logic        tWe, tOor, expErr;
  logic [31:0] expRdt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit found;
    int p, w;
    if (!rst_n) begin
      mPhase = 0; mPtr = 0; mGrant = 0; mJust = 0;
    end else begin
      case (mPhase)
        0: begin
          found = 0;
          for (int k = 0; k < NP; k++) begin
            p = (mPtr + k) % NP;
            if (!found && mCyc[p] && !(mJust && p == mGrant)) begin
              found = 1; mGrant = p;
            end
          end
          mJust = 0;
          if (found) begin
            mPhase = 1;
            mPtr   = (mGrant + 1) % NP;
            tAdr = mAdr[mGrant]; tDat = mDat[mGrant];
            tSel = mSel[mGrant]; tWe  = mWe[mGrant];
            tOor = (tAdr >> (AW + 2)) != 0;
          end
        end
        1: begin
          mPhase = 2;
          expErr = tOor;
          expRdt = 32'h0;
          w = int'((tAdr >> 2) % 32);
          if (!tOor) begin
            if (tWe) begin
              for (int b = 0; b < NL; b++)
                if (tSel[b]) refMem[w][8*b +: 8] = tDat[8*b +: 8];
            end else begin
              expRdt = refMem[w];
            end
          end
        end
        default: begin
          mPhase = 0; mJust = 1;
        end
      endcase
    end
  endtask

  task automatic checkAllOutputs();
    logic [2:0] ea;
    ea = (mPhase == 2) ? 3'(1 << mGrant) : 3'd0;
    checkOutput("ack",    bus.o_ack,   ea);
    checkOutput("err",    bus.o_err,   (mPhase == 2) && expErr);
    checkOutput("rdt",    bus.o_rdt,   (mPhase == 2) ? expRdt : 32'h0);
    checkOutput("grant",  bus.o_grant, (mPhase != 0) ? mGrant : 0);
    checkOutput("ram_en", ramEn,       rst_n && (mPhase == 1) && !tOor);
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkAllOutputs();
  endtask

  task automatic randomMasters();
    for (int p = 0; p < NP; p++) begin
      if (mPhase == 2 && mGrant == p) begin
        mCyc[p] = 0; waitAck[p] = 0;
      end else if (mPhase == 1 && mGrant == p && mCyc[p] && $urandom_range(0, 7) == 0) begin
        mCyc[p] = 0; waitAck[p] = 1;
      end
      if (!mCyc[p] && !waitAck[p] && $urandom_range(0, 2) == 0) begin
        mCyc[p] = 1;
        mWe[p]  = 1'($urandom_range(0, 1));
        mSel[p] = 4'($urandom);
        mDat[p] = $urandom;
        mAdr[p] = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h80) : ($urandom & 32'h7f);
      end
    end
  endtask

  logic [2:0]  ackTable [12];
  logic [15:0] wv [16];

  initial begin
    for (int i = 0; i < 32; i++) initMem[i] = $urandom;
    initMem[2] = 32'h1234_5678;
    initMem[5] = 32'h5555_5555;
    for (int i = 0; i < 32; i++) refMem[i] = initMem[i];
    for (int p = 0; p < NP; p++) begin
      mCyc[p] = 0; mWe[p] = 0; mAdr[p] = 0; mDat[p] = 0; mSel[p] = 0; waitAck[p] = 0;
    end
    bus1.i_cyc = 0; bus1.i_we = 0; bus1.i_adr = 0; bus1.i_dat = 0; bus1.i_sel = 0;
    tOor = 0; expErr = 0; expRdt = 0;

    // Reset state
    rst_n = 0; loadMem = 1;
    applyStimulus();
    loadMem = 0;
    applyStimulus();
    checkOutput("rst_ack",   bus.o_ack,   3'b000);
    checkOutput("rst_grant", bus.o_grant, 3'd0);
    checkOutput("rst_ramen", ramEn,       1'b0);
    rst_n = 1;
    applyStimulus();

    // Port 1 partial write, then read back
    mWe[1] = 1; mAdr[1] = 32'h8; mDat[1] = 32'hA5A5_A5A5; mSel[1] = 4'b0011; mCyc[1] = 1;
    applyStimulus();
    checkOutput("wr_access_ack", bus.o_ack, 3'b000);
    checkOutput("wr_ramwe",      ramWe,     4'b0011);
    checkOutput("wr_rama",       ramA,      5'd2);
    applyStimulus();
    checkOutput("wr_ack", bus.o_ack, 3'b010);
    mCyc[1] = 0;
    applyStimulus();
    applyStimulus();
    mWe[1] = 0; mCyc[1] = 1;
    applyStimulus();
    checkOutput("rd_access_ack", bus.o_ack, 3'b000);
    applyStimulus();
    checkOutput("rd_ack",  bus.o_ack, 3'b010);
    checkOutput("rd_data", bus.o_rdt, 32'h1234_A5A5);
    mCyc[1] = 0;
    applyStimulus();
    applyStimulus();

    // Out-of-range read on port 0
    mWe[0] = 0; mAdr[0] = 32'h80; mCyc[0] = 1;
    applyStimulus();
    checkOutput("oor_ramen", ramEn, 1'b0);
    applyStimulus();
    checkOutput("oor_ack", bus.o_ack, 3'b001);
    checkOutput("oor_err", bus.o_err, 1'b1);
    checkOutput("oor_rdt", bus.o_rdt, 32'h0);
    mCyc[0] = 0;
    applyStimulus();
    applyStimulus();

    // Three held simultaneous requests rotate 0,1,2,0 every three cycles
    rst_n = 0;
    applyStimulus();
    rst_n = 1;
    for (int i = 0; i < 12; i++) ackTable[i] = 3'b000;
    ackTable[1] = 3'b001; ackTable[4] = 3'b010; ackTable[7] = 3'b100; ackTable[10] = 3'b001;
    for (int p = 0; p < NP; p++) begin
      mWe[p] = 0; mAdr[p] = 32'($urandom_range(0, 31)) << 2; mCyc[p] = 1;
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      checkOutput("rr_order", bus.o_ack, ackTable[i]);
    end
    for (int p = 0; p < NP; p++) mCyc[p] = 0;
    applyStimulus();
    applyStimulus();

    // Reset during the ACCESS cycle of a full-word write
    mWe[0] = 1; mAdr[0] = 32'h14; mDat[0] = 32'hDEAD_BEEF; mSel[0] = 4'hF; mCyc[0] = 1;
    applyStimulus();
    checkOutput("pre_rst_we", ramWe, 4'hF);
    rst_n = 0;
    #1;
    checkOutput("rst_mid_we", ramWe, 4'h0);
    checkOutput("rst_mid_en", ramEn, 1'b0);
    mCyc[0] = 0;
    applyStimulus();
    rst_n = 1;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("post_rst_grant", bus.o_grant, 3'd0);
    mWe[0] = 0; mAdr[0] = 32'h14; mCyc[0] = 1;
    mWe[1] = 0; mAdr[1] = 32'h0;  mCyc[1] = 1;
    applyStimulus();
    checkOutput("post_rst_ptr", bus.o_grant, 3'd0);
    applyStimulus();
    checkOutput("post_rst_ack",  bus.o_ack, 3'b001);
    checkOutput("post_rst_word", bus.o_rdt, 32'h5555_5555);
    mCyc[0] = 0;

    // Randomized masters
    for (int c = 0; c < 600; c++) begin
      randomMasters();
      applyStimulus();
    end
    for (int p = 0; p < NP; p++) begin
      mCyc[p] = 0; waitAck[p] = 0;
    end
    for (int i = 0; i < 4; i++) applyStimulus();

    // Single-master instance: back-to-back writes of all words, then reads
    begin
      int cyc, lastAck, acks, idx;
      bit writing;
      for (int i = 0; i < 16; i++) wv[i] = 16'($urandom);
      writing = 1; idx = 0; acks = 0; cyc = 0; lastAck = -1;
      bus1.i_we = 1; bus1.i_adr = 0; bus1.i_dat = wv[0]; bus1.i_sel = 2'b11; bus1.i_cyc = 1;
      for (int c = 0; c < 200 && acks < 32; c++) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus1.o_ack[0]) begin
          checkOutput("n1_err", bus1.o_err, 1'b0);
          if (!writing) checkOutput("n1_rdata", bus1.o_rdt, wv[idx]);
          if (lastAck < 0) checkOutput("n1_latency", cyc, 2);
          else             checkOutput("n1_spacing", cyc - lastAck, 3);
          lastAck = cyc;
          acks++;
          idx++;
          if (idx == 16 && writing) begin
            writing = 0; idx = 0;
          end
          if (acks == 32) begin
            bus1.i_cyc = 0;
          end else begin
            bus1.i_we  = writing;
            bus1.i_adr = 32'(idx) << 2;
            bus1.i_dat = writing ? wv[idx] : 16'h0;
          end
        end
      end
      bus1.i_cyc = 0;
      checkOutput("n1_ack_count", acks, 32);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3, number of bus master ports (1..8); port 0 has highest priority after reset.
REQ-002 SHALL have parameter DW, default 32, data width in bits (multiple of 8); lane count NL = DW/8.
REQ-003 SHALL have parameter AW, default 5, RAM word-address width; depth = 2^AW words.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_cyc  in  NPORTS  per-port request; held high by the master until its ack.
REQ-007 i_adr  in  NPORTS*32  per-port byte address; port p occupies bits [32p+31:32p].
REQ-008 i_we  in  NPORTS  per-port write (1) / read (0).
REQ-009 i_dat  in  NPORTS*DW  per-port write data.
REQ-010 i_sel  in  NPORTS*NL  per-port byte-lane enables.
REQ-011 o_ack  out  NPORTS  one-cycle completion pulse, one-hot or zero.
REQ-012 o_rdt  out  DW  read data, valid only while any o_ack bit is high.
REQ-013 o_err  out  1  pulses with o_ack when the completed access was out of range.
REQ-014 o_grant  out  3  index of the port currently owning the RAM (0 when idle).
REQ-015 ram_en, ram_a[AW], ram_we[NL], ram_di[DW]  out  RAM macro port; ram_do[DW]  in  RAM read data, valid one cycle after ram_en.

Function
REQ-016 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS when any eligible i_cyc is high at the edge; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-017 Arbitration in IDLE SHALL be round-robin: search ports starting at rr_ptr, ascending with wrap to 0; first eligible requester wins; its index is registered as grant.
REQ-018 On entering ACCESS, rr_ptr SHALL become (grant+1) mod NPORTS.
REQ-019 Port granted last SHALL be ineligible during the single IDLE cycle that follows its ACK (suppresses duplicate service of a held cyc); it is eligible again thereafter.
REQ-020 Word address = i_adr[grant][AW+1:2]; access is out of range when i_adr[grant][31:AW+2] != 0.
REQ-021 In ACCESS, in range: ram_en=1, ram_a=word address, ram_di=i_dat[grant], ram_we=i_sel[grant] when i_we[grant]=1, else 0; all combinational from the granted port.
REQ-022 In ACCESS, out of range: ram_en=0, ram_we=0; out-of-range flag registered for ACK.
REQ-023 Outside ACCESS: ram_en=0, ram_we=0, ram_a=0, ram_di=0.
REQ-024 In ACK: o_ack[grant]=1; o_rdt=ram_do for in-range reads, 0 for writes and out-of-range accesses; o_err=1 iff out of range.
REQ-025 Outside ACK: o_ack=0, o_rdt=0, o_err=0.
REQ-026 Latency: cyc sampled high at edge t -> ACCESS during cycle t+1 -> ack during cycle t+2; max throughput one transaction per 3 cycles.
REQ-027 Write with i_sel=0 SHALL complete with ack and write no bytes.
REQ-028 If the granted port drops i_cyc during ACCESS, the RAM operation still completes and o_ack is still pulsed; masters ignore stray acks.
REQ-029 Simultaneous requests SHALL be served one per transaction in rotating order; no port waits more than NPORTS transactions.
REQ-030 NPORTS=1 SHALL degenerate to a single-master pass-through with identical timing.

Reset
REQ-031 While rst_n=0, ram_en and ram_we SHALL be forced to 0 combinationally, so no write commits in the reset cycle, even mid-ACCESS.
REQ-032 At an edge with rst_n=0: state=IDLE, rr_ptr=0, grant=0, eligibility mask cleared; an in-flight transaction is abandoned without ack.
REQ-033 After reset all outputs are 0 until the first request is sampled.

Verification
REQ-034 Port 1 writes adr 0x0000_0008, dat 0xA5A5A5A5, sel 4'b0011; later reads 0x08 -> RAM word 2 bytes[15:0]=0xA5A5, upper bytes unchanged; read ack 2 cycles after cyc sampled.
REQ-035 Ports 0,1,2 raise cyc in the same cycle and hold -> acks in order 0,1,2, then 0 again, each 3 cycles apart; no ack pulses twice for one held request.
REQ-036 Port 0 reads adr 0x0000_0080 (AW=5) -> ram_en never asserted, o_ack[0]=1 with o_err=1, o_rdt=0.
REQ-037 rst_n low during ACCESS of a write sel=4'b1111 -> ram_we=0 that cycle, target word unchanged, no ack, grant=0 and rr_ptr=0 afterwards.
REQ-038 NPORTS=1, DW=16, AW=4: back-to-back writes to words 0..15 then reads -> data matches, one ack per 3 cycles, o_err=0.
